// File: rtl/gb_host_bridge.sv
// gb_host_bridge: single-outstanding host master driving the ghostbus addr/din/we bus.
// Build option GB_HOST_WRITE_ACK_EN: when defined, every write returns an acknowledge response.
module gb_host_bridge #(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_write_i,
    input  logic [AW-1:0] cmd_addr_i,
    input  logic [DW-1:0] cmd_wdata_i,
    output logic          resp_valid_o,
    input  logic          resp_ready_i,
    output logic [DW-1:0] resp_data_o,
    output logic          resp_write_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_din_o,
    output logic          bus_we_o,
    input  logic [DW-1:0] bus_dout_i,
    output logic          busy_o
);
    // state   | meaning
    // S_IDLE  | ready for a command, cmd_ready_o high
    // S_ISSUE | command on the bus, write strobe high for writes
    // S_WAIT  | counting down the remaining read latency
    // S_RESP  | response presented until resp_ready_i
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam int CW = 4;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [DW-1:0] resp_data_q, resp_data_d;
    logic          resp_write_q, resp_write_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_din_q, bus_din_d;
    logic          bus_we_q, bus_we_d;
    logic          busy_q, busy_d;
    logic          accept;

    // cmd_ready_q is only ever high in S_IDLE, so it qualifies the handshake alone.
    assign accept = cmd_valid_i && cmd_ready_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (write_q) begin
`ifdef GB_HOST_WRITE_ACK_EN
                    state_d = S_RESP;
`else
                    state_d = S_IDLE;
`endif
                end else if (RD_LAT == 0) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        write_d      = write_q;
        cmd_ready_d  = cmd_ready_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_write_d = resp_write_q;
        bus_addr_d   = bus_addr_q;
        bus_din_d    = bus_din_q;
        bus_we_d     = 1'b0;
        busy_d       = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                cmd_ready_d = !accept;
                if (accept) begin
                    bus_addr_d = cmd_addr_i;
                    bus_din_d  = cmd_wdata_i;
                    write_d    = cmd_write_i;
                    bus_we_d   = cmd_write_i;
                end
            end
            S_ISSUE: begin
                if (write_q) begin
`ifdef GB_HOST_WRITE_ACK_EN
                    resp_valid_d = 1'b1;
                    resp_data_d  = '0;
                    resp_write_d = 1'b1;
`else
                    cmd_ready_d  = 1'b1;
`endif
                end else if (RD_LAT == 0) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = bus_dout_i;
                    resp_write_d = 1'b0;
                end else begin
                    // One latency cycle is the ISSUE cycle itself.
                    cnt_d = CW'(RD_LAT - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = bus_dout_i;
                    resp_write_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    cmd_ready_d  = 1'b1;
                end
            end
            default: begin
                cmd_ready_d  = 1'b0;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q        <= '0;
            write_q      <= 1'b0;
            cmd_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_write_q <= 1'b0;
            bus_addr_q   <= '0;
            bus_din_q    <= '0;
            bus_we_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            cmd_ready_q  <= cmd_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_write_q <= resp_write_d;
            bus_addr_q   <= bus_addr_d;
            bus_din_q    <= bus_din_d;
            bus_we_q     <= bus_we_d;
            busy_q       <= busy_d;
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_write_o = resp_write_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_din_o    = bus_din_q;
    assign bus_we_o     = bus_we_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_gb_host_bridge.sv
// Directed bench for gb_host_bridge: three instances with RD_LAT = 1, 0 and 4.
// Write-ack expectations follow GB_HOST_WRITE_ACK_EN.
module tb_gb_host_bridge;
    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0]        cmd_valid;
    logic              cmd_write;
    logic [23:0]       cmd_addr;
    logic [31:0]       cmd_wdata;
    logic              resp_ready;
    logic [2:0]        cmd_ready, resp_valid, resp_write, bus_we, busy;
    logic [2:0][31:0]  resp_data, bus_din, bus_dout;
    logic [2:0][23:0]  bus_addr;
    logic [2:0]        busy_prev, issue;
    logic [31:0]       dq1;
    logic [3:0][31:0]  p4;
    int                n_checks = 0;
    int                n_fail = 0;

    localparam logic [31:0] BAD = 32'hBAD0BAD0;

    always #5 clk = ~clk;

    gb_host_bridge #(.AW(24), .DW(32), .RD_LAT(1)) u_lat1 (
        .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]),
        .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready), .resp_data_o(resp_data[0]),
        .resp_write_o(resp_write[0]), .bus_addr_o(bus_addr[0]), .bus_din_o(bus_din[0]),
        .bus_we_o(bus_we[0]), .bus_dout_i(bus_dout[0]), .busy_o(busy[0]));

    gb_host_bridge #(.AW(24), .DW(32), .RD_LAT(0)) u_lat0 (
        .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]),
        .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready), .resp_data_o(resp_data[1]),
        .resp_write_o(resp_write[1]), .bus_addr_o(bus_addr[1]), .bus_din_o(bus_din[1]),
        .bus_we_o(bus_we[1]), .bus_dout_i(bus_dout[1]), .busy_o(busy[1]));

    gb_host_bridge #(.AW(24), .DW(32), .RD_LAT(4)) u_lat4 (
        .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(cmd_valid[2]), .cmd_ready_o(cmd_ready[2]),
        .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .resp_valid_o(resp_valid[2]), .resp_ready_i(resp_ready), .resp_data_o(resp_data[2]),
        .resp_write_o(resp_write[2]), .bus_addr_o(bus_addr[2]), .bus_din_o(bus_din[2]),
        .bus_we_o(bus_we[2]), .bus_dout_i(bus_dout[2]), .busy_o(busy[2]));

    // Peripheral model: data is only valid exactly RD_LAT cycles after the issue cycle.
    function automatic logic [31:0] fmod(input logic [23:0] a);
        return (a == 24'h000020) ? 32'hCAFEF00D : {8'h5A, a};
    endfunction

    assign issue = busy & ~busy_prev;
    always @(posedge clk) begin
        busy_prev <= busy;
        dq1       <= issue[0] ? fmod(bus_addr[0]) : BAD;
        p4[0]     <= issue[2] ? fmod(bus_addr[2]) : BAD;
        p4[1]     <= p4[0];
        p4[2]     <= p4[1];
        p4[3]     <= p4[2];
    end
    assign bus_dout[0] = dq1;
    assign bus_dout[1] = issue[1] ? fmod(bus_addr[1]) : BAD;
    assign bus_dout[2] = p4[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Drives one command for one edge; returns at the sample point of cycle 1.
    task automatic send(input int k, input logic w, input logic [23:0] a, input logic [31:0] d);
        cmd_write    = w;
        cmd_addr     = a;
        cmd_wdata    = d;
        cmd_valid[k] = 1'b1;
        tick();
        cmd_valid[k] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int exp_cnt;
        logic [31:0] held;
        rst_n      = 1'b0;
        cmd_valid  = '0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        resp_ready = 1'b1;

        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_bus_we", 32'(bus_we), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_bus_addr", 32'(bus_addr[0]), 32'h0);
        chk("rst_resp_data", resp_data[0], 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_cmd_ready_before_edge", 32'(cmd_ready), 32'h0);
        tick();
        chk("rel_cmd_ready_after_edge", 32'(cmd_ready), 32'h7);

        // Read RD_LAT=1, resp_valid from E3
        send(0, 1'b0, 24'h000020, 32'h0);
        chk("rd1_c1_busy", 32'(busy[0]), 32'h1);
        chk("rd1_c1_we", 32'(bus_we[0]), 32'h0);
        chk("rd1_c1_cmd_ready", 32'(cmd_ready[0]), 32'h0);
        tick();
        chk("rd1_c2_resp_valid", 32'(resp_valid[0]), 32'h0);
        tick();
        chk("rd1_c3_resp_valid", 32'(resp_valid[0]), 32'h1);
        chk("rd1_c3_resp_data", resp_data[0], 32'hCAFEF00D);
        chk("rd1_c3_resp_write", 32'(resp_write[0]), 32'h0);
        tick();
        chk("rd1_c4_resp_valid", 32'(resp_valid[0]), 32'h0);
        chk("rd1_c4_cmd_ready", 32'(cmd_ready[0]), 32'h1);

        // Single write
        send(0, 1'b1, 24'h000010, 32'hDEADBEEF);
        chk("wr_c1_we", 32'(bus_we[0]), 32'h1);
        chk("wr_c1_addr", 32'(bus_addr[0]), 32'h000010);
        chk("wr_c1_din", bus_din[0], 32'hDEADBEEF);
        chk("wr_c1_cmd_ready", 32'(cmd_ready[0]), 32'h0);
        tick();
        chk("wr_c2_we", 32'(bus_we[0]), 32'h0);
`ifdef GB_HOST_WRITE_ACK_EN
        chk("wr_c2_resp_valid", 32'(resp_valid[0]), 32'h1);
        chk("wr_c2_resp_write", 32'(resp_write[0]), 32'h1);
        chk("wr_c2_resp_data", resp_data[0], 32'h0);
        chk("wr_c2_cmd_ready", 32'(cmd_ready[0]), 32'h0);
        tick();
        chk("wr_c3_resp_valid", 32'(resp_valid[0]), 32'h0);
        chk("wr_c3_cmd_ready", 32'(cmd_ready[0]), 32'h1);
        exp_cnt = 4;
`else
        chk("wr_c2_resp_valid", 32'(resp_valid[0]), 32'h0);
        chk("wr_c2_cmd_ready", 32'(cmd_ready[0]), 32'h1);
        chk("wr_c2_busy", 32'(busy[0]), 32'h0);
        tick();
        chk("wr_c3_resp_valid", 32'(resp_valid[0]), 32'h0);
        exp_cnt = 6;
`endif

        // Back-to-back writes with cmd_valid held for 12 cycles
        cmd_write    = 1'b1;
        cmd_addr     = 24'h000004;
        cmd_wdata    = 32'h1;
        cmd_valid[0] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus_we[0]) cnt++;
        end
        cmd_valid[0] = 1'b0;
        chk("b2b_write_count", 32'(cnt), 32'(exp_cnt));
        chk("b2b_resp_write", 32'(resp_write[0]), 32'h0
`ifdef GB_HOST_WRITE_ACK_EN
            | 32'h1
`endif
        );
        tick();
        tick();

        // Read RD_LAT=0, resp_valid from E2
        send(1, 1'b0, 24'h000044, 32'h0);
        chk("rd0_c1_resp_valid", 32'(resp_valid[1]), 32'h0);
        tick();
        chk("rd0_c2_resp_valid", 32'(resp_valid[1]), 32'h1);
        chk("rd0_c2_resp_data", resp_data[1], 32'h5A000044);
        tick();
        chk("rd0_c3_resp_valid", 32'(resp_valid[1]), 32'h0);
        chk("rd0_c3_cmd_ready", 32'(cmd_ready[1]), 32'h1);

        // Read RD_LAT=4, resp_valid from E6
        send(2, 1'b0, 24'h000100, 32'h0);
        repeat (4) tick();
        chk("rd4_c5_resp_valid", 32'(resp_valid[2]), 32'h0);
        tick();
        chk("rd4_c6_resp_valid", 32'(resp_valid[2]), 32'h1);
        chk("rd4_c6_resp_data", resp_data[2], 32'h5A000100);
        tick();
        chk("rd4_c7_resp_valid", 32'(resp_valid[2]), 32'h0);

        // Backpressure on RD_LAT=1 read
        resp_ready = 1'b0;
        send(0, 1'b0, 24'h000030, 32'h0);
        tick();
        tick();
        chk("bp_resp_valid", 32'(resp_valid[0]), 32'h1);
        held = resp_data[0];
        chk("bp_resp_data", held, 32'h5A000030);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                cmd_write    = 1'b1;
                cmd_addr     = 24'h000077;
                cmd_wdata    = 32'h12345678;
                cmd_valid[0] = 1'b1;
            end
            tick();
            cmd_valid[0] = 1'b0;
            chk("bp_hold_valid", 32'(resp_valid[0]), 32'h1);
            chk("bp_hold_data", resp_data[0], 32'h5A000030);
            chk("bp_hold_cmd_ready", 32'(cmd_ready[0]), 32'h0);
            chk("bp_hold_we", 32'(bus_we[0]), 32'h0);
        end
        chk("bp_addr_kept", 32'(bus_addr[0]), 32'h000030);
        resp_ready = 1'b1;
        tick();
        chk("bp_release_cmd_ready", 32'(cmd_ready[0]), 32'h1);
        chk("bp_release_resp_valid", 32'(resp_valid[0]), 32'h0);

        // Reset during WAIT of an RD_LAT=4 read
        send(2, 1'b0, 24'h000200, 32'h0);
        tick();
        tick();
        chk("rw_wait_busy", 32'(busy[2]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw_busy", 32'(busy[2]), 32'h0);
        chk("rw_cmd_ready", 32'(cmd_ready[2]), 32'h0);
        chk("rw_resp_valid", 32'(resp_valid[2]), 32'h0);
        chk("rw_bus_addr", 32'(bus_addr[2]), 32'h0);
        chk("rw_bus_din", bus_din[2], 32'h0);
        chk("rw_resp_data", resp_data[2], 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rw_rel_cmd_ready_before", 32'(cmd_ready[2]), 32'h0);
        tick();
        chk("rw_rel_cmd_ready_after", 32'(cmd_ready[2]), 32'h1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (resp_valid[2]) cnt++;
        end
        chk("rw_no_response", 32'(cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gb_host_bridge.md
# gb_host_bridge

Upstream host-side master for the ghostbus fabric. Accepts single-word read/write commands on a valid/ready stream, drives the shared bus (addr/din/we) that feeds interposer and peripheral modules, and captures their dout after a fixed read latency. Returns each read result on a valid/ready response stream. One transaction is in flight at a time, so bus timing stays deterministic for every downstream stage.

## Interface
- AW, 24, bus address width
- DW, 32, bus data width
- RD_LAT, 1, cycles from the bus issue edge to valid bus_dout; legal range 0..15

- clk  input  1  bus clock; all logic is rising-edge
- rst_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  bridge can accept a command
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  AW  target address
- cmd_wdata  input  DW  write data; ignored for reads
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts the response
- resp_data  output  DW  read data; 0 for write acks
- resp_write  output  1  1 = this response acknowledges a write
- bus_addr  output  AW  bus address to downstream modules
- bus_din  output  DW  bus write data to downstream modules
- bus_we  output  1  bus write strobe, one cycle per write
- bus_dout  input  DW  read data returned by downstream modules
- busy  output  1  state is not IDLE

## Operation
- All outputs are registered. Reset values: cmd_ready=0, resp_valid=0, resp_data=0, resp_write=0, bus_addr=0, bus_din=0, bus_we=0, busy=0. The state is IDLE.
- cmd_ready rises on the first clk edge after rst_n deasserts. It is then 1 exactly while the state is IDLE.
- States:
  - IDLE
    - On the edge where cmd_valid and cmd_ready are both high, latch cmd_addr into bus_addr, cmd_wdata into bus_din, and cmd_write into an internal register.
    - Set bus_we to cmd_write, drop cmd_ready, and go to ISSUE.
  - ISSUE (1 cycle): bus_we is high in this cycle for writes only. Then:
    - Write: go to RESP if the write ack is enabled (see Configuration), otherwise go to IDLE.
    - Read with RD_LAT=0: capture bus_dout into resp_data at the end of ISSUE and go to RESP.
    - Read with RD_LAT>0: load the latency counter with RD_LAT-1 and go to WAIT.
  - WAIT
    - Decrement the counter each cycle.
    - In the cycle the counter is 0, capture bus_dout into resp_data and go to RESP.
  - RESP
    - resp_valid=1. resp_data and resp_write are held stable until resp_ready is seen high.
    - On the handshake edge, clear resp_valid and go to IDLE.
- bus_addr and bus_din keep their last value between transactions. bus_we is 0 outside ISSUE.
- cmd_valid is ignored outside IDLE; no command is queued.
- A write ack carries resp_data=0 and resp_write=1. A read response carries resp_write=0.
- Asserting rst_n low in any state forces the reset values immediately. The in-flight transaction is dropped and produces no response.

## Timing
Cycle numbers count from the accept edge, E0.
- Write, no ack: bus_we is high in cycle 1. cmd_ready is high again from E2.
- Write, ack enabled: resp_valid is high from E2. With resp_ready held high, cmd_ready is high again from E3.
- Read: resp_valid is high from edge E(RD_LAT+2).
  - RD_LAT=1: resp_valid high from E3.
  - RD_LAT=0: resp_valid high from E2.
- Response handshake: resp_valid falls and cmd_ready rises on the same edge.
- Minimum command spacing, with resp_ready held high:
  - Read: RD_LAT+3 cycles.
  - Write, ack enabled: 3 cycles.
  - Write, no ack: 2 cycles.
- resp_ready low: RESP holds indefinitely with no timeout.

## Configuration
- GB_HOST_WRITE_ACK_EN defined: every write produces a response (resp_write=1, resp_data=0) after ISSUE.
- GB_HOST_WRITE_ACK_EN undefined: writes return ISSUE→IDLE directly, and resp_valid is asserted for reads only. resp_write is then constant 0.

## Test plan
- Write: cmd_write=1, addr=0x000010, wdata=0xDEADBEEF, macro undefined → bus_we high only in cycle 1 with bus_addr=0x000010 and bus_din=0xDEADBEEF; no resp_valid; cmd_ready high at E2.
- Read, RD_LAT=1: model returns 0xCAFEF00D one cycle after address 0x000020 → resp_valid at E3 with resp_data=0xCAFEF00D and resp_write=0.
- Read, RD_LAT=0, combinational model → resp_valid at E2. Read, RD_LAT=4 → resp_valid at E6.
- Backpressure: hold resp_ready=0 for 5 cycles during a read response → resp_valid and resp_data stay stable, cmd_ready stays 0, and a cmd_valid pulse in that window is ignored. Raise resp_ready → cmd_ready is high on the next edge.
- Reset: assert rst_n low during WAIT of a read (RD_LAT=4) → all outputs at reset values immediately; no response after release; cmd_ready returns 1 one edge after release.
- Macro defined: write addr=0x000004, data=0x1 → resp_valid at E2 with resp_write=1 and resp_data=0. Back-to-back writes with resp_ready=1 are accepted every 3 cycles.
